// File: rtl/serial_bit_comparator.sv
// Bit-serial unsigned magnitude comparator. It walks the operands MSB first
// through a one-bit equal/greater cascade, with a start/busy/done handshake.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   start  compare request, only sampled in IDLE
//   a, b   operands, captured at the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle pulse when eq/gt/lt are updated
//   eq/gt/lt  last result (A==B, A>B, A<B), held between done pulses
module serial_bit_comparator #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic           e;
    logic           g;
    logic [CW-1:0]  cnt;

    logic ai;
    logic bi;
    logic g_next;
    logic e_next;
    logic last;
    logic stop;

    assign ai     = sa[WIDTH-1];
    assign bi     = sb[WIDTH-1];
    assign g_next = g | (e & ai & ~bi);
    assign e_next = e & ~(ai ^ bi);

    // This edge processes bit 0 once cnt has counted WIDTH-1 bits.
    assign last = (cnt == CW'(WIDTH - 1));
    // A cleared equal flag can never come back, so the outcome is fixed.
    assign stop = last || ((EARLY_EXIT != 0) && !e_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            e     <= 1'b0;
            g     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        e     <= 1'b1;
                        g     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    sa  <= {sa[WIDTH-2:0], 1'b0};
                    sb  <= {sb[WIDTH-2:0], 1'b0};
                    e   <= e_next;
                    g   <= g_next;
                    cnt <= cnt + CW'(1);
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        eq    <= e_next;
                        gt    <= g_next;
                        lt    <= ~e_next & ~g_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_comparator.sv
// Directed bench for serial_bit_comparator: four instances cover
// WIDTH 8/4 with early exit off/on; results use {eq,gt,lt} ordering.
module tb_serial_bit_comparator;

    logic       clk;
    logic       reset;
    logic [3:0] start_v;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] eq_v;
    logic [3:0] gt_v;
    logic [3:0] lt_v;

    int checks = 0;
    int passed = 0;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    serial_bit_comparator #(.WIDTH(8), .EARLY_EXIT(0)) dut8 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]),
        .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0])
    );

    serial_bit_comparator #(.WIDTH(8), .EARLY_EXIT(1)) dut8e (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]),
        .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1])
    );

    serial_bit_comparator #(.WIDTH(4), .EARLY_EXIT(0)) dut4 (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .a(a_v[2][3:0]), .b(b_v[2][3:0]),
        .busy(busy_v[2]), .done(done_v[2]),
        .eq(eq_v[2]), .gt(gt_v[2]), .lt(lt_v[2])
    );

    serial_bit_comparator #(.WIDTH(4), .EARLY_EXIT(1)) dut4e (
        .clk(clk), .reset(reset), .start(start_v[3]),
        .a(a_v[3][3:0]), .b(b_v[3][3:0]),
        .busy(busy_v[3]), .done(done_v[3]),
        .eq(eq_v[3]), .gt(gt_v[3]), .lt(lt_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] res_of(input int s);
        return {eq_v[s], gt_v[s], lt_v[s]};
    endfunction

    // Called at a sample point (#1 after an edge) with the instance in IDLE.
    // Returns at the sample point one cycle after done, instance in IDLE.
    task automatic do_cmp(
        input  int         sel,
        input  logic [7:0] av,
        input  logic [7:0] bv,
        output int         lat,
        output logic [2:0] res,
        output int         nbusy,
        output bit         held,
        output bit         dup
    );
        logic [2:0] prev;
        prev     = res_of(sel);
        a_v[sel] = av;
        b_v[sel] = bv;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        // operands may change freely once accepted
        a_v[sel] = ~av;
        b_v[sel] = ~bv;
        lat   = -1;
        res   = 3'bxxx;
        held  = 1'b1;
        nbusy = busy_v[sel] ? 1 : 0;
        if (res_of(sel) !== prev) held = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done_v[sel]) begin
                lat = n;
                res = res_of(sel);
                break;
            end
            if (busy_v[sel]) nbusy++;
            if (res_of(sel) !== prev) held = 1'b0;
        end
        @(posedge clk);
        #1;
        dup = done_v[sel];
    endtask

    task automatic test_reset;
        logic [19:0] outs;
        outs = {busy_v, done_v, eq_v, gt_v, lt_v};
        checks++;
        if (outs !== 20'h0)
            $display("FAIL reset_outputs got=%h want=%h", outs, 20'h0);
        else
            passed++;
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        outs = {busy_v, done_v, eq_v, gt_v, lt_v};
        checks++;
        if (outs !== 20'h0)
            $display("FAIL idle_after_reset got=%h want=%h", outs, 20'h0);
        else
            passed++;
    endtask

    task automatic test_equal;
        int lat, nb;
        logic [2:0] r;
        bit h, d;
        do_cmp(0, 8'hA5, 8'hA5, lat, r, nb, h, d);
        checks++;
        if (lat !== 8) $display("FAIL eq_latency got=%0d want=8", lat);
        else passed++;
        checks++;
        if (r !== R_EQ) $display("FAIL eq_result got=%b want=%b", r, R_EQ);
        else passed++;
        checks++;
        if (nb !== 8) $display("FAIL eq_busy_cycles got=%0d want=8", nb);
        else passed++;
        checks++;
        if (d !== 1'b0) $display("FAIL eq_single_done got=%b want=0", d);
        else passed++;
    endtask

    task automatic test_gt_then_lt;
        int lat, nb;
        logic [2:0] r;
        bit h, d;
        do_cmp(0, 8'h80, 8'h7F, lat, r, nb, h, d);
        checks++;
        if (r !== R_GT || lat !== 8)
            $display("FAIL gt_80_7f got=%b/%0d want=%b/8", r, lat, R_GT);
        else passed++;
        do_cmp(0, 8'h00, 8'h01, lat, r, nb, h, d);
        checks++;
        if (h !== 1'b1) $display("FAIL gt_held got=%b want=1", h);
        else passed++;
        checks++;
        if (r !== R_LT || lat !== 8)
            $display("FAIL lt_00_01 got=%b/%0d want=%b/8", r, lat, R_LT);
        else passed++;
    endtask

    task automatic test_early_exit;
        int lat, nb;
        logic [2:0] r;
        bit h, d;
        do_cmp(1, 8'h80, 8'h00, lat, r, nb, h, d);
        checks++;
        if (r !== R_GT || lat !== 1 || d !== 1'b0)
            $display("FAIL ee_80_00 got=%b/%0d/%b want=%b/1/0",
                     r, lat, d, R_GT);
        else passed++;
        do_cmp(1, 8'h12, 8'h13, lat, r, nb, h, d);
        checks++;
        if (r !== R_LT || lat !== 8)
            $display("FAIL ee_12_13 got=%b/%0d want=%b/8", r, lat, R_LT);
        else passed++;
        do_cmp(1, 8'h3C, 8'h34, lat, r, nb, h, d);
        checks++;
        if (r !== R_GT || lat !== 5 || nb !== 5)
            $display("FAIL ee_3c_34 got=%b/%0d/%0d want=%b/5/5",
                     r, lat, nb, R_GT);
        else passed++;
        do_cmp(0, 8'h80, 8'h00, lat, r, nb, h, d);
        checks++;
        if (r !== R_GT || lat !== 8)
            $display("FAIL noee_80_00 got=%b/%0d want=%b/8", r, lat, R_GT);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int         t [4];
        logic [2:0] r [4];
        int         nd;
        nd = 0;
        a_v[0] = 8'h10;
        b_v[0] = 8'h20;
        start_v[0] = 1'b1;
        for (int n = 0; n <= 28; n++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                if (nd < 4) begin
                    t[nd] = n;
                    r[nd] = res_of(0);
                end
                nd++;
            end
            if (n == 0) begin
                a_v[0] = 8'hFF;
                b_v[0] = 8'h00;
            end
            if (n == 8) begin
                a_v[0] = 8'h55;
                b_v[0] = 8'h55;
            end
            if (n == 10) begin
                a_v[0] = 8'hFF;
                b_v[0] = 8'h00;
            end
            if (n == 20) begin
                a_v[0] = 8'h00;
                b_v[0] = 8'hFF;
            end
            if (n == 28) start_v[0] = 1'b0;
        end
        checks++;
        if (nd !== 3) $display("FAIL b2b_done_count got=%0d want=3", nd);
        else passed++;
        if (nd == 3) begin
            checks++;
            if (t[0] !== 8 || t[1] !== 18 || t[2] !== 28)
                $display("FAIL b2b_timing got=%0d,%0d,%0d want=8,18,28",
                         t[0], t[1], t[2]);
            else passed++;
            checks++;
            if (r[0] !== R_LT || r[1] !== R_EQ || r[2] !== R_GT)
                $display("FAIL b2b_results got=%b,%b,%b want=%b,%b,%b",
                         r[0], r[1], r[2], R_LT, R_EQ, R_GT);
            else passed++;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0)
            $display("FAIL b2b_idle got=%b%b want=00", busy_v[0], done_v[0]);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int lat, nb, extra;
        logic [2:0] r;
        bit h, d;
        logic [4:0] outs;
        a_v[0] = 8'hF0;
        b_v[0] = 8'h0F;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy_v[0] !== 1'b1 || res_of(0) !== R_GT)
            $display("FAIL pre_reset got=%b/%b want=1/%b",
                     busy_v[0], res_of(0), R_GT);
        else passed++;
        #2 reset = 1'b1;
        #1;
        outs = {busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]};
        checks++;
        if (outs !== 5'b0)
            $display("FAIL async_reset got=%b want=00000", outs);
        else passed++;
        @(posedge clk);
        #3 reset = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL abandoned_done got=%0d want=0", extra);
        else passed++;
        do_cmp(0, 8'h0F, 8'hF0, lat, r, nb, h, d);
        checks++;
        if (r !== R_LT || lat !== 8)
            $display("FAIL after_reset got=%b/%0d want=%b/8", r, lat, R_LT);
        else passed++;
    endtask

    task automatic test_exhaustive4;
        int lat, nb, p;
        logic [2:0] r, exp;
        bit h, d;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                exp = {x == y, x > y, x < y};
                p = 4;
                for (int i = 3; i >= 0; i--) begin
                    if (x[i] != y[i]) begin
                        p = 4 - i;
                        break;
                    end
                end
                do_cmp(2, 8'(x), 8'(y), lat, r, nb, h, d);
                checks++;
                if (r !== exp || lat !== 4 || d !== 1'b0)
                    $display("FAIL w4 a=%0d b=%0d got=%b/%0d/%b want=%b/4/0",
                             x, y, r, lat, d, exp);
                else passed++;
                do_cmp(3, 8'(x), 8'(y), lat, r, nb, h, d);
                checks++;
                if (r !== exp || lat !== p || d !== 1'b0)
                    $display("FAIL w4ee a=%0d b=%0d got=%b/%0d/%b want=%b/%0d/0",
                             x, y, r, lat, d, exp, p);
                else passed++;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_v = 4'b0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 8'h00;
            b_v[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_equal;
        test_gt_then_lt;
        test_early_exit;
        test_back_to_back;
        test_reset_mid;
        test_exhaustive4;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
